radix_gate: RTL and testbench

- N-input, one-output routing gate for the partitioned hash join fabric.
- Accepts a tuple from any of NUM_IN upstream channels when its tag's radix field equals this gate's ID; arbitrates among matching channels round-robin.
- Forwards accepted tuples through a 2-entry output skid buffer, so in_ready never depends combinationally on ready_4_output.
- Propagates end-of-phase (last_processed) once every input is drained, and keeps a count of forwarded tuples.

---
 rtl/phj_pkg.sv | 21 ++
 rtl/gate_skid_buffer.sv | 51 +++++
 rtl/radix_gate.sv | 170 +++++++++++++++++
 tb/tb_radix_gate.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/phj_pkg.sv
// Shared types and helpers for the partitioned hash join fabric.
package phj_pkg;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        WORK = 2'd1,
        DONE = 2'd2
    } gate_state_t;

    localparam int TAG_W    = 32;
    localparam int SERIAL_W = 64;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        if (v == 32'hFFFF_FFFF) begin
            return v;
        end else begin
            return v + 32'd1;
        end
    endfunction

endpackage

// File: rtl/gate_skid_buffer.sv
// Two-entry FIFO decoupling the radix gate's grant path from downstream ready.
module gate_skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] mem_r [2];
    logic         wr_ptr_r;
    logic         rd_ptr_r;
    logic [1:0]   count_r;
    logic         do_push_s;
    logic         do_pop_s;

    assign do_push_s = push && (count_r != 2'd2);
    assign do_pop_s  = pop && (count_r != 2'd0);

    // Storage, pointers and occupancy; simultaneous push/pop leaves count unchanged.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_r[0] <= '0;
            mem_r[1] <= '0;
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (do_pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/radix_gate.sv
// Radix routing gate: round-robin accepts tuples whose tag radix matches ID,
// forwards them through a skid buffer and signals end-of-phase once drained.
module radix_gate
    import phj_pkg::*;
#(
    parameter int INPUT_SIZE   = 64,
    parameter int NUM_IN       = 4,
    parameter int RADIX_BITS   = 2,
    parameter int DECISION_LSB = 0,
    parameter int ID           = 0
) (
    input  logic                                clk,
    input  logic                                resetn,
    input  logic [NUM_IN-1:0]                   in_valid,
    output logic [NUM_IN-1:0]                   in_ready,
    input  logic [NUM_IN-1:0][INPUT_SIZE-1:0]   in_data,
    input  logic [NUM_IN-1:0][31:0]             in_tag,
    input  logic [NUM_IN-1:0][63:0]             in_serialnum,
    input  logic [NUM_IN-1:0]                   in_was_joined,
    input  logic [NUM_IN-1:0]                   in_last_processed,
    input  logic                                ready_4_output,
    output logic                                out_valid,
    output logic [INPUT_SIZE-1:0]               out_data,
    output logic [31:0]                         out_tag,
    output logic [63:0]                         out_serialnum,
    output logic                                out_was_joined,
    output logic                                out_last_processed,
    output logic [31:0]                         tuple_count
);

    localparam int PTR_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    typedef struct packed {
        logic [INPUT_SIZE-1:0] data;
        logic [TAG_W-1:0]      tag;
        logic [SERIAL_W-1:0]   serialnum;
        logic                  was_joined;
    } tuple_t;

    gate_state_t      state_r;
    gate_state_t      state_next_s;
    logic [PTR_W-1:0] rr_ptr_r;
    logic [PTR_W-1:0] grant_idx_s;
    logic             grant_valid_s;
    logic [NUM_IN-1:0] match_s;
    logic [NUM_IN-1:0] in_ready_s;
    logic             space_s;
    logic             pop_s;
    logic             olp_r;
    logic [31:0]      tuple_count_r;
    logic [1:0]       count_s;
    tuple_t           push_tuple_s;
    tuple_t           head_s;

    // Per-channel radix match against this gate's partition index.
    always_comb begin
        match_s = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            match_s[i] = in_valid[i] &&
                         (in_tag[i][DECISION_LSB +: RADIX_BITS] == RADIX_BITS'(ID));
        end
    end

    // Space comes from registered occupancy only, keeping in_ready off the downstream path.
    assign space_s = (count_s != 2'd2);

    // Round-robin search starting at rr_ptr, first match wins.
    always_comb begin
        int  idx_v;
        logic hit_v;
        grant_valid_s = 1'b0;
        grant_idx_s   = '0;
        idx_v         = 0;
        hit_v         = 1'b0;
        if (space_s && (state_r == WORK)) begin
            for (int k = 0; k < NUM_IN; k++) begin
                idx_v         = (int'(rr_ptr_r) + k) % NUM_IN;
                hit_v         = match_s[PTR_W'(idx_v)] && !grant_valid_s;
                grant_idx_s   = hit_v ? PTR_W'(idx_v) : grant_idx_s;
                grant_valid_s = grant_valid_s || hit_v;
            end
        end else begin
            grant_valid_s = 1'b0;
            grant_idx_s   = '0;
        end
    end

    // One-hot ready to the granted channel.
    always_comb begin
        in_ready_s = '0;
        if (grant_valid_s) begin
            in_ready_s[grant_idx_s] = 1'b1;
        end else begin
            in_ready_s = '0;
        end
    end

    // Gather the granted channel's tuple for the buffer.
    always_comb begin
        push_tuple_s.data       = in_data[grant_idx_s];
        push_tuple_s.tag        = in_tag[grant_idx_s];
        push_tuple_s.serialnum  = in_serialnum[grant_idx_s];
        push_tuple_s.was_joined = in_was_joined[grant_idx_s];
    end

    // Phase state: drained means every channel finished, nothing valid, buffer empty.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            INIT: state_next_s = WORK;
            WORK: begin
                if ((&in_last_processed) && !(|in_valid) && (count_s == 2'd0)) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = WORK;
                end
            end
            DONE: begin
                if (!(&in_last_processed)) begin
                    state_next_s = WORK;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: state_next_s = INIT;
        endcase
    end

    // State, round-robin pointer, end-of-phase flag and saturating tuple counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r       <= INIT;
            rr_ptr_r      <= '0;
            olp_r         <= 1'b0;
            tuple_count_r <= 32'd0;
        end else begin
            state_r <= state_next_s;
            olp_r   <= (state_next_s == DONE);
            if (grant_valid_s) begin
                rr_ptr_r <= (grant_idx_s == PTR_W'(NUM_IN - 1)) ? '0 : grant_idx_s + PTR_W'(1);
            end
            if (pop_s) begin
                tuple_count_r <= sat_inc32(tuple_count_r);
            end
        end
    end

    gate_skid_buffer #(
        .W($bits(tuple_t))
    ) u_skid (
        .clk       (clk),
        .resetn    (resetn),
        .push      (grant_valid_s),
        .push_data (push_tuple_s),
        .pop       (pop_s),
        .head      (head_s),
        .count     (count_s)
    );

    assign pop_s              = out_valid && ready_4_output;
    assign in_ready           = in_ready_s;
    assign out_valid          = (count_s != 2'd0);
    assign out_data           = head_s.data;
    assign out_tag            = head_s.tag;
    assign out_serialnum      = head_s.serialnum;
    assign out_was_joined     = head_s.was_joined;
    assign out_last_processed = olp_r;
    assign tuple_count        = tuple_count_r;

endmodule

// File: tb/tb_radix_gate.sv
// Directed bench for radix_gate (NUM_IN=4, RADIX_BITS=2, ID=2).
module tb_radix_gate;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic [3:0]        in_valid;
    logic [3:0]        in_ready;
    logic [3:0][63:0]  in_data;
    logic [3:0][31:0]  in_tag;
    logic [3:0][63:0]  in_serialnum;
    logic [3:0]        in_was_joined;
    logic [3:0]        in_last_processed;
    logic              ready_4_output;
    logic              out_valid;
    logic [63:0]       out_data;
    logic [31:0]       out_tag;
    logic [63:0]       out_serialnum;
    logic              out_was_joined;
    logic              out_last_processed;
    logic [31:0]       tuple_count;

    int checks = 0;
    int errors = 0;
    int seq [4];

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] tag0;
        logic [63:0] data0;
        logic        rdy;
        logic [3:0]  exp_ready;
        logic        exp_ov;
        logic [63:0] exp_data;
    } vec_t;

    vec_t vecs [7];

    logic [3:0] t3_ready [9] = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000,
                                 4'b0000, 4'b0100, 4'b0000, 4'b0000};
    int         t3_head  [9] = '{-1, 0, 0, 0, 0, 0, 1, 2, -1};

    radix_gate #(
        .INPUT_SIZE(64), .NUM_IN(4), .RADIX_BITS(2), .DECISION_LSB(0), .ID(2)
    ) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
        .in_serialnum(in_serialnum), .in_was_joined(in_was_joined),
        .in_last_processed(in_last_processed), .ready_4_output(ready_4_output),
        .out_valid(out_valid), .out_data(out_data), .out_tag(out_tag),
        .out_serialnum(out_serialnum), .out_was_joined(out_was_joined),
        .out_last_processed(out_last_processed), .tuple_count(tuple_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive_all(input logic [3:0] v);
        in_valid = v;
        for (int i = 0; i < 4; i++) begin
            in_tag[i]        = 32'h2 | (32'(i) << 8);
            in_data[i]       = {32'(i), 32'(seq[i])};
            in_serialnum[i]  = 64'(i * 1000 + seq[i]);
            in_was_joined[i] = seq[i][0];
        end
    endtask

    task automatic tick();
        logic [3:0] g;
        #1;
        g = in_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (g[i]) seq[i]++;
        end
    endtask

    task automatic reset_dut();
        resetn = 1'b0;
        in_valid = 4'b0;
        ready_4_output = 1'b0;
        in_last_processed = 4'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        logic [63:0] exp_d;
        vecs[0] = '{4'b0001, 32'h2, 64'hA1,  1'b1, 4'b0000, 1'b0, 64'h0};
        vecs[1] = '{4'b0001, 32'h2, 64'hA1,  1'b1, 4'b0001, 1'b0, 64'h0};
        vecs[2] = '{4'b0001, 32'h1, 64'hB0B, 1'b1, 4'b0000, 1'b1, 64'hA1};
        vecs[3] = '{4'b0001, 32'h1, 64'hB0B, 1'b1, 4'b0000, 1'b0, 64'h0};
        vecs[4] = '{4'b0001, 32'h6, 64'hC0C, 1'b1, 4'b0001, 1'b0, 64'h0};
        vecs[5] = '{4'b0000, 32'h6, 64'hC0C, 1'b1, 4'b0000, 1'b1, 64'hC0C};
        vecs[6] = '{4'b0000, 32'h0, 64'h0,   1'b1, 4'b0000, 1'b0, 64'h0};
        for (int i = 0; i < 4; i++) seq[i] = 0;
        drive_all(4'b0);

        // Single channel: tag filtering, INIT blocks grants, 1-cycle latency.
        reset_dut();
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_olp", 64'(out_last_processed), 64'd0);
        chk("reset_count", 64'(tuple_count), 64'd0);
        for (int r = 0; r < 7; r++) begin
            in_valid       = vecs[r].valid;
            in_tag[0]      = vecs[r].tag0;
            in_data[0]     = vecs[r].data0;
            ready_4_output = vecs[r].rdy;
            #1;
            chk($sformatf("vec%0d_in_ready", r), 64'(in_ready), 64'(vecs[r].exp_ready));
            chk($sformatf("vec%0d_out_valid", r), 64'(out_valid), 64'(vecs[r].exp_ov));
            if (vecs[r].exp_ov) chk($sformatf("vec%0d_out_data", r), out_data, vecs[r].exp_data);
            @(posedge clk);
            #1;
        end
        chk("t1_count", 64'(tuple_count), 64'd2);

        // Four channels always matching: grant order 0,1,2,3,...
        reset_dut();
        for (int i = 0; i < 4; i++) seq[i] = 0;
        ready_4_output = 1'b1;
        drive_all(4'hF);
        #1;
        chk("t2_init_ready", 64'(in_ready), 64'd0);
        tick();
        for (int n = 0; n < 9; n++) begin
            drive_all((n < 8) ? 4'hF : 4'h0);
            #1;
            chk($sformatf("t2_ready%0d", n), 64'(in_ready), (n < 8) ? (64'd1 << (n % 4)) : 64'd0);
            if (n >= 1) begin
                chk($sformatf("t2_ov%0d", n), 64'(out_valid), 64'd1);
                chk($sformatf("t2_data%0d", n), out_data, {32'((n - 1) % 4), 32'((n - 1) / 4)});
                chk($sformatf("t2_serial%0d", n), out_serialnum, 64'(((n - 1) % 4) * 1000 + (n - 1) / 4));
                chk($sformatf("t2_joined%0d", n), 64'(out_was_joined), 64'(((n - 1) / 4) % 2));
            end
            tick();
        end
        chk("t2_empty", 64'(out_valid), 64'd0);
        chk("t2_count", 64'(tuple_count), 64'd8);

        // Backpressure: two accepted, outputs held, FIFO order kept.
        for (int c = 0; c < 9; c++) begin
            ready_4_output = (c >= 5);
            drive_all((c <= 6) ? 4'hF : 4'h0);
            #1;
            chk($sformatf("t3_ready%0d", c), 64'(in_ready), 64'(t3_ready[c]));
            chk($sformatf("t3_ov%0d", c), 64'(out_valid), 64'(t3_head[c] >= 0));
            if (t3_head[c] >= 0) chk($sformatf("t3_data%0d", c), out_data, {32'(t3_head[c]), 32'd2});
            tick();
        end
        chk("t3_count", 64'(tuple_count), 64'd11);

        // End-of-phase waits for the buffer to drain, clears when a channel resumes.
        ready_4_output = 1'b0;
        in_last_processed = 4'hF;
        drive_all(4'b0010);
        #1;
        chk("t4_grant_ch1", 64'(in_ready), 64'b0010);
        tick();
        drive_all(4'b0000);
        chk("t4_olp_b", 64'(out_last_processed), 64'd0);
        chk("t4_ov_b", 64'(out_valid), 64'd1);
        tick();
        chk("t4_olp_c", 64'(out_last_processed), 64'd0);
        ready_4_output = 1'b1;
        tick();
        chk("t4_olp_e", 64'(out_last_processed), 64'd0);
        chk("t4_ov_e", 64'(out_valid), 64'd0);
        tick();
        chk("t4_olp_f", 64'(out_last_processed), 64'd1);
        drive_all(4'b0001);
        #1;
        chk("t4_done_no_grant", 64'(in_ready), 64'd0);
        tick();
        drive_all(4'b0000);
        chk("t4_olp_g", 64'(out_last_processed), 64'd1);
        in_last_processed = 4'b1101;
        tick();
        chk("t4_olp_h", 64'(out_last_processed), 64'd0);
        in_last_processed = 4'b0000;
        chk("t4_count", 64'(tuple_count), 64'd12);

        // Asynchronous reset with two tuples buffered.
        ready_4_output = 1'b0;
        drive_all(4'hF);
        tick();
        drive_all(4'hF);
        tick();
        #2;
        resetn = 1'b0;
        #1;
        chk("t5_async_ov", 64'(out_valid), 64'd0);
        chk("t5_async_count", 64'(tuple_count), 64'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        ready_4_output = 1'b1;
        drive_all(4'hF);
        #1;
        chk("t5_init_ready", 64'(in_ready), 64'd0);
        chk("t5_init_ov", 64'(out_valid), 64'd0);
        tick();
        drive_all(4'hF);
        exp_d = {32'd0, 32'(seq[0])};
        #1;
        chk("t5_first_grant", 64'(in_ready), 64'b0001);
        chk("t5_no_stale", 64'(out_valid), 64'd0);
        tick();
        drive_all(4'h0);
        chk("t5_ov", 64'(out_valid), 64'd1);
        chk("t5_data", out_data, exp_d);
        tick();
        tick();
        tick();

        // Counter saturation.
        force dut.tuple_count_r = 32'hFFFF_FFFE;
        #1;
        release dut.tuple_count_r;
        for (int c = 0; c < 5; c++) begin
            drive_all((c < 3) ? 4'hF : 4'h0);
            tick();
            if (c == 1) chk("t6_count_1pop", 64'(tuple_count), 64'hFFFF_FFFF);
        end
        chk("t6_count_3pops", 64'(tuple_count), 64'hFFFF_FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
